// File: rtl/instr_data_mem_ldr.sv
// Unified instruction/data memory for the 8-bit core, with a boot-loader
// streaming port. The LOAD/RUN mode FSM decides who owns the arrays: the
// loader in LOAD, the core in RUN. Reads are registered; a same-cycle data
// write to the read address is forwarded so the core sees the new value.
module instr_data_mem_ldr #(
    parameter int IADDR_W = 10,
    parameter int IDATA_W = 16,
    parameter int DADDR_W = 8,
    parameter int DDATA_W = 8,
    parameter int LDCNT_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IADDR_W-1:0] prog_ctr,
    output logic [IDATA_W-1:0] instr_mem_out,
    input  logic [DADDR_W-1:0] data_rd_addr,
    output logic [DDATA_W-1:0] datamem_rd_data,
    input  logic [DADDR_W-1:0] data_wr_addr,
    input  logic [DDATA_W-1:0] datamem_wr_data,
    input  logic               store_to_mem,
    input  logic               ld_start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_sel,
    input  logic [IADDR_W-1:0] ld_addr,
    input  logic [IDATA_W-1:0] ld_data,
    input  logic               ld_done,
    output logic               mem_run,
    output logic [LDCNT_W-1:0] ld_count
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic               mem_run_q;
    logic               ld_ready_q;
    logic [LDCNT_W-1:0] ld_count_q;
    logic [LDCNT_W-1:0] ld_count_d;
    logic [IDATA_W-1:0] instr_q;
    logic [DDATA_W-1:0] rd_data_q;

    logic [IDATA_W-1:0] instr_mem [2**IADDR_W];
    logic [DDATA_W-1:0] data_mem  [2**DADDR_W];

    logic xfer;
    logic ld_iwr;
    logic ld_dwr;
    logic core_dwr;
    logic rd_bypass;

    // Count of accepted loader words; holds at all-ones instead of wrapping.
    function automatic logic [LDCNT_W-1:0] sat_inc(input logic [LDCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Write enables and read-forwarding decode; nothing is written while in reset.
    always_comb begin
        xfer       = rst_n && (state_q == ST_LOAD) && ld_valid;
        ld_iwr     = xfer && !ld_sel;
        ld_dwr     = xfer && ld_sel;
        core_dwr   = rst_n && (state_q == ST_RUN) && store_to_mem;
        rd_bypass  = store_to_mem && (data_wr_addr == data_rd_addr);
        ld_count_d = xfer ? sat_inc(ld_count_q) : ld_count_q;
    end

    // LOAD/RUN mode FSM with registered status outputs and load counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            mem_run_q  <= 1'b0;
            ld_ready_q <= 1'b1;
            ld_count_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    ld_count_q <= ld_count_d;
                    if (ld_done) begin
                        state_q    <= ST_RUN;
                        mem_run_q  <= 1'b1;
                        ld_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ld_start) begin
                        state_q    <= ST_LOAD;
                        mem_run_q  <= 1'b0;
                        ld_ready_q <= 1'b1;
                        ld_count_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_LOAD;
                    mem_run_q  <= 1'b0;
                    ld_ready_q <= 1'b1;
                    ld_count_q <= '0;
                end
            endcase
        end
    end

    // Instruction array is written only by the loader.
    always_ff @(posedge clk) begin
        if (ld_iwr) begin
            instr_mem[ld_addr] <= ld_data;
        end
    end

    // Data array: loader writes in LOAD, core stores in RUN; never both at once.
    always_ff @(posedge clk) begin
        if (ld_dwr) begin
            data_mem[ld_addr[DADDR_W-1:0]] <= ld_data[DDATA_W-1:0];
        end else if (core_dwr) begin
            data_mem[data_wr_addr] <= datamem_wr_data;
        end
    end

    // Registered reads; LOAD (and reset) present NOP/zero to the stalled core.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == ST_LOAD) begin
            instr_q   <= '0;
            rd_data_q <= '0;
        end else begin
            instr_q   <= instr_mem[prog_ctr];
            rd_data_q <= rd_bypass ? datamem_wr_data : data_mem[data_rd_addr];
        end
    end

    assign instr_mem_out   = instr_q;
    assign datamem_rd_data = rd_data_q;
    assign mem_run         = mem_run_q;
    assign ld_ready        = ld_ready_q;
    assign ld_count        = ld_count_q;

endmodule

// File: tb/tb_instr_data_mem_ldr.sv
// Bench for instr_data_mem_ldr: directed test-plan sequence followed by
// randomized traffic. A behavioural model predicts every cycle's outputs
// into a scoreboard queue; a separate monitor compares after each edge.
module tb_instr_data_mem_ldr;

    localparam int IW      = 10;
    localparam int ID      = 16;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] prog_ctr;
    logic [ID-1:0] instr_mem_out;
    logic [AW-1:0] data_rd_addr;
    logic [DW-1:0] datamem_rd_data;
    logic [AW-1:0] data_wr_addr;
    logic [DW-1:0] datamem_wr_data;
    logic          store_to_mem;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_sel;
    logic [IW-1:0] ld_addr;
    logic [ID-1:0] ld_data;
    logic          ld_done;
    logic          mem_run;
    logic [CW-1:0] ld_count;

    instr_data_mem_ldr #(
        .IADDR_W(IW), .IDATA_W(ID), .DADDR_W(AW), .DDATA_W(DW), .LDCNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_ctr(prog_ctr), .instr_mem_out(instr_mem_out),
        .data_rd_addr(data_rd_addr), .datamem_rd_data(datamem_rd_data),
        .data_wr_addr(data_wr_addr), .datamem_wr_data(datamem_wr_data),
        .store_to_mem(store_to_mem), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .mem_run(mem_run), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID-1:0] instr;
        bit            ik;
        logic [DW-1:0] rd;
        bit            rk;
        int            cnt;
        bit            run;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: plain arrays with "known" flags, mode bit, counter.
    bit            m_run = 1'b0;
    int            m_cnt = 0;
    logic [ID-1:0] m_imem [1 << IW];
    bit            m_ik   [1 << IW];
    logic [DW-1:0] m_dmem [1 << AW];
    bit            m_dk   [1 << AW];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_step(output exp_t e);
        e.instr = '0; e.ik = 1'b1; e.rd = '0; e.rk = 1'b1;
        if (!rst_n) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            if (ld_valid) begin
                if (ld_sel) begin
                    m_dmem[ld_addr[AW-1:0]] = ld_data[DW-1:0];
                    m_dk[ld_addr[AW-1:0]]   = 1'b1;
                end else begin
                    m_imem[ld_addr] = ld_data;
                    m_ik[ld_addr]   = 1'b1;
                end
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (ld_done) m_run = 1'b1;
        end else begin
            e.instr = m_imem[prog_ctr];
            e.ik    = m_ik[prog_ctr];
            if (store_to_mem && data_wr_addr == data_rd_addr) begin
                e.rd = datamem_wr_data;
            end else begin
                e.rd = m_dmem[data_rd_addr];
                e.rk = m_dk[data_rd_addr];
            end
            if (store_to_mem) begin
                m_dmem[data_wr_addr] = datamem_wr_data;
                m_dk[data_wr_addr]   = 1'b1;
            end
            if (ld_start) begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
        e.cnt = m_cnt;
        e.run = m_run;
    endtask

    task automatic idle();
        prog_ctr = '0; data_rd_addr = '0; data_wr_addr = '0; datamem_wr_data = '0;
        store_to_mem = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0;
        ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    endtask

    // Predict the coming edge, push it, then step one clock (ends at negedge).
    task automatic tick();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_w(input logic s, input logic [IW-1:0] a, input logic [ID-1:0] d);
        idle();
        ld_valid = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
        tick();
    endtask

    // Monitor: compare each predicted response shortly after its edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("mem_run",  32'(mem_run),  32'(mon_e.run));
                chk("ld_ready", 32'(ld_ready), 32'(!mon_e.run));
                chk("ld_count", 32'(ld_count), 32'(mon_e.cnt));
                if (mon_e.ik) chk("instr_mem_out",   32'(instr_mem_out),   32'(mon_e.instr));
                if (mon_e.rk) chk("datamem_rd_data", 32'(datamem_rd_data), 32'(mon_e.rd));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        // Reset
        tick(); tick();
        chk("rst_count", 32'(ld_count), 32'd0);
        chk("rst_run",   32'(mem_run),  32'd0);
        chk("rst_instr", 32'(instr_mem_out), 32'd0);
        rst_n = 1'b1;

        // First load session
        load_w(1'b0, 10'd0, 16'h1001);
        load_w(1'b0, 10'd1, 16'h2002);
        load_w(1'b0, 10'd2, 16'h3003);
        load_w(1'b1, 10'd5, 16'h00A5);
        load_w(1'b1, 10'd6, 16'h005A);
        idle(); ld_done = 1'b1; tick(); idle();
        chk("load_count5", 32'(ld_count), 32'd5);
        chk("load_run",    32'(mem_run),  32'd1);
        prog_ctr = 10'd1; data_rd_addr = 8'd5; tick();
        chk("fetch_pc1", 32'(instr_mem_out),   32'h2002);
        chk("read_d5",   32'(datamem_rd_data), 32'hA5);

        // Reload; stores during LOAD must be dropped
        idle(); ld_start = 1'b1; tick(); idle();
        chk("reload_run",   32'(mem_run),  32'd0);
        chk("reload_count", 32'(ld_count), 32'd0);
        store_to_mem = 1'b1; data_wr_addr = 8'd5; datamem_wr_data = 8'hFF; tick();
        chk("reload_instr", 32'(instr_mem_out), 32'd0);
        load_w(1'b1, 10'h010, 16'h0000);
        load_w(1'b1, 10'd4,   16'h0044);
        load_w(1'b1, 10'd3,   16'h0000);
        idle(); ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 10'd9; ld_data = 16'h00C3; ld_done = 1'b1;
        tick(); idle();
        chk("valid_done_count", 32'(ld_count), 32'd4);
        chk("valid_done_run",   32'(mem_run),  32'd1);

        // RUN: bypass, then distinct addresses
        store_to_mem = 1'b1; data_wr_addr = 8'h10; data_rd_addr = 8'h10; datamem_wr_data = 8'h7E;
        tick(); idle();
        chk("bypass", 32'(datamem_rd_data), 32'h7E);
        store_to_mem = 1'b1; data_wr_addr = 8'd3; datamem_wr_data = 8'h11; data_rd_addr = 8'd4;
        tick(); idle();
        chk("diff_rd4", 32'(datamem_rd_data), 32'h44);
        data_rd_addr = 8'd3; tick();
        chk("diff_rd3", 32'(datamem_rd_data), 32'h11);
        data_rd_addr = 8'd9; tick();
        chk("rd_d9", 32'(datamem_rd_data), 32'hC3);
        data_rd_addr = 8'd5; tick();
        chk("load_store_ignored", 32'(datamem_rd_data), 32'hA5);

        // Counter saturation
        idle(); ld_start = 1'b1; tick();
        for (int i = 0; i < 20; i++) load_w(1'b0, 10'(100 + i), 16'(16'hB000 + i));
        chk("count_sat", 32'(ld_count), 32'(CNT_MAX));
        idle(); ld_done = 1'b1; tick(); idle();

        // Reset in the middle of a LOAD session
        ld_start = 1'b1; tick();
        load_w(1'b0, 10'd20, 16'hABCD);
        load_w(1'b1, 10'd30, 16'h0077);
        idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_count", 32'(ld_count), 32'd0);
        chk("midrst_run",   32'(mem_run),  32'd0);
        chk("midrst_rd",    32'(datamem_rd_data), 32'd0);
        ld_done = 1'b1; tick(); idle();
        prog_ctr = 10'd0; tick();
        chk("midrst_keep_i0", 32'(instr_mem_out), 32'h1001);
        prog_ctr = 10'd20; data_rd_addr = 8'd30; tick();
        chk("midrst_partial_d30", 32'(datamem_rd_data), 32'h77);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            idle();
            rst_n           = ($urandom_range(0, 199) != 0);
            prog_ctr        = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 2));
            data_rd_addr    = 8'($urandom_range(0, 15));
            data_wr_addr    = 8'($urandom_range(0, 15));
            datamem_wr_data = 8'($urandom);
            store_to_mem    = 1'($urandom_range(0, 1));
            ld_start        = ($urandom_range(0, 29) == 0);
            ld_valid        = 1'($urandom_range(0, 1));
            ld_sel          = 1'($urandom_range(0, 1));
            ld_addr         = 10'($urandom_range(8, 1023));
            ld_data         = 16'($urandom);
            ld_done         = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick(); tick();

        // Drain: every prediction must have been consumed by the monitor
        repeat (4) @(posedge clk);
        #2;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
